// File: rtl/tag_cam.sv
// Fully associative tag CAM with round-robin allocation, single-entry invalidate and sequential flush.
// Optional macro TAG_CAM_INVALID_FIRST_EN: prefer the lowest-index invalid entry as fill victim.
module tag_cam #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WAY_NUM    = 4,
  parameter int unsigned ENTRY_NUM  = 16,
  localparam int unsigned IDX_W     = $clog2(ENTRY_NUM),
  localparam int unsigned OFF_W     = $clog2(WAY_NUM) + $clog2(DATA_WIDTH / 8),
  localparam int unsigned TAG_WIDTH = ADDR_WIDTH - OFF_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Lookup_Valid,
  input  logic [ADDR_WIDTH-1:0] Lookup_Addr,
  output logic                  Hit_Valid,
  output logic                  Hit,
  output logic [IDX_W-1:0]      Hit_Index,
  input  logic                  Fill_Valid,
  input  logic [ADDR_WIDTH-1:0] Fill_Addr,
  output logic                  Fill_Ready,
  output logic [IDX_W-1:0]      Fill_Index,
  output logic                  Evict_Valid,
  output logic [TAG_WIDTH-1:0]  Evict_Tag,
  input  logic                  Inv_Valid,
  input  logic [IDX_W-1:0]      Inv_Index,
  input  logic                  Flush,
  output logic                  Busy
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       sweep_ptr, sweep_nxt;
  logic [IDX_W-1:0]       rr_ptr;
  logic [ENTRY_NUM-1:0]   valid, valid_nxt;
  logic [TAG_WIDTH-1:0]   tags [ENTRY_NUM];

  logic [TAG_WIDTH-1:0]   lk_tag, fill_tag;
  logic                   lk_hit, fill_hit;
  logic [IDX_W-1:0]       lk_idx, fill_idx, victim;
  logic                   fill_acc, alloc, rr_adv;
  logic                   unused_offset_bits;

  assign lk_tag   = Lookup_Addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign fill_tag = Fill_Addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign unused_offset_bits = ^{Lookup_Addr[OFF_W-1:0], Fill_Addr[OFF_W-1:0]};

  // Priority encoders: descending scan so the lowest matching index wins
  always_comb begin
    lk_hit   = 1'b0;
    lk_idx   = '0;
    fill_hit = 1'b0;
    fill_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid[i] && (tags[i] == fill_tag)) begin
        fill_hit = 1'b1;
        fill_idx = IDX_W'(i);
      end
    end
  end

  assign Fill_Ready = (state == S_IDLE);
  assign fill_acc   = Fill_Valid & Fill_Ready;
  assign alloc      = fill_acc & ~fill_hit;
  assign Busy       = (state == S_FLUSH);

`ifdef TAG_CAM_INVALID_FIRST_EN
  logic             inv_any;
  logic [IDX_W-1:0] inv_idx;

  always_comb begin
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        inv_any = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
  end

  assign victim = inv_any ? inv_idx : rr_ptr;
  assign rr_adv = alloc & ~inv_any;
`else
  assign victim = rr_ptr;
  assign rr_adv = alloc;
`endif

  assign Fill_Index  = fill_hit ? fill_idx : victim;
  assign Evict_Valid = alloc & valid[victim];
  assign Evict_Tag   = alloc ? tags[victim] : '0;

  // Next state: flush sweep, then invalidate, then fill (fill wins on its own index)
  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_ptr;
    valid_nxt = valid;
    case (state)
      S_IDLE: begin
        if (Flush) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        valid_nxt[sweep_ptr] = 1'b0;
        sweep_nxt            = sweep_ptr + IDX_W'(1);
        if (sweep_ptr == IDX_W'(ENTRY_NUM - 1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (Inv_Valid && !(fill_acc && (Fill_Index == Inv_Index))) valid_nxt[Inv_Index] = 1'b0;
    if (alloc) valid_nxt[victim] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      sweep_ptr <= '0;
      rr_ptr    <= '0;
      valid     <= '0;
      Hit_Valid <= 1'b0;
      Hit       <= 1'b0;
      Hit_Index <= '0;
    end else begin
      state     <= state_nxt;
      sweep_ptr <= sweep_nxt;
      valid     <= valid_nxt;
      if (rr_adv) rr_ptr <= rr_ptr + IDX_W'(1);
      Hit_Valid <= Lookup_Valid;
      // Lookups issued during a flush always miss
      Hit       <= Lookup_Valid & (state == S_IDLE) & lk_hit;
      Hit_Index <= (Lookup_Valid && (state == S_IDLE) && lk_hit) ? lk_idx : '0;
    end
  end

  // Tags are cleared on reset so Evict_Tag is deterministic for never-written victims
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRY_NUM; i++) tags[i] <= '0;
    end else if (alloc) begin
      tags[victim] <= fill_tag;
    end
  end

endmodule
